// File: rtl/bf_pkg.sv
// Shared types and constants for the BF core, its host I/O bridge and their benches.
package bf_pkg;

  typedef logic [7:0] byte_t;

  localparam byte_t DROP_MAX = 8'hFF;

  // BF opcodes as they appear in program memory (ASCII), plus the terminator.
  localparam byte_t OP_INC   = 8'h2B;  // '+'
  localparam byte_t OP_DEC   = 8'h2D;  // '-'
  localparam byte_t OP_LEFT  = 8'h3C;  // '<'
  localparam byte_t OP_RIGHT = 8'h3E;  // '>'
  localparam byte_t OP_OUT   = 8'h2E;  // '.'
  localparam byte_t OP_IN    = 8'h2C;  // ','
  localparam byte_t OP_JZ    = 8'h5B;  // '['
  localparam byte_t OP_JNZ   = 8'h5D;  // ']'
  localparam byte_t OP_NUL   = 8'h00;

endpackage

// File: rtl/bf_byte_fifo.sv
// First-word-fall-through byte FIFO; a push into a full FIFO is taken only when a pop frees the slot.
module bf_byte_fifo
  import bf_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic [7:0]    head,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW-1:0] PTR_ONE = 1;

  byte_t          mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]    count_q, count_d;
  logic           push_ok, pop_ok;

  assign full   = (count_q == DEPTH_C);
  assign empty  = (count_q == '0);
  assign count  = count_q;
  assign pop_ok = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign head   = empty ? 8'h00 : mem_q[rd_ptr_q];

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the zero count already hides stale contents.
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/bf_io_bridge.sv
// Host-side byte I/O bridge for the BF core: host->core input FIFO, core->host output FIFO,
// drop accounting for the unbackpressured core output, and run-completion reporting.
module bf_io_bridge
  import bf_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  output logic [7:0]    core_in,
  output logic          core_in_valid,
  input  logic          core_in_reading,
  input  logic [7:0]    core_out,
  input  logic          core_out_enable,
  input  logic          core_halted,
  input  logic [7:0]    host_rx_data,
  input  logic          host_rx_valid,
  output logic          host_rx_ready,
  output logic [7:0]    host_tx_data,
  output logic          host_tx_valid,
  input  logic          host_tx_ready,
  output logic [AW:0]   in_count,
  output logic [AW:0]   out_count,
  output logic          overflow,
  output logic [7:0]    drop_count,
  output logic          done
);

  logic  in_full, in_empty, out_full, out_empty;
  logic  in_push, in_pop, out_pop, out_drop;
  logic  overflow_q, overflow_d;
  byte_t drop_count_q, drop_count_d;

  // The host side never gets the pop-frees-a-slot allowance: ready depends on occupancy alone.
  assign host_rx_ready = !in_full;
  assign in_push       = host_rx_valid && host_rx_ready;
  assign core_in_valid = !in_empty;
  assign in_pop        = core_in_reading && core_in_valid;

  assign host_tx_valid = !out_empty;
  assign out_pop       = host_tx_valid && host_tx_ready;
  assign out_drop      = core_out_enable && out_full && !out_pop;

  bf_byte_fifo #(.DEPTH(DEPTH), .AW(AW)) u_in_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (in_push),
    .push_data (host_rx_data),
    .pop       (in_pop),
    .head      (core_in),
    .count     (in_count),
    .full      (in_full),
    .empty     (in_empty)
  );

  bf_byte_fifo #(.DEPTH(DEPTH), .AW(AW)) u_out_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (core_out_enable),
    .push_data (core_out),
    .pop       (out_pop),
    .head      (host_tx_data),
    .count     (out_count),
    .full      (out_full),
    .empty     (out_empty)
  );

  always_comb begin
    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;
    if (out_drop) begin
      overflow_d = 1'b1;
      if (drop_count_q != DROP_MAX) drop_count_d = drop_count_q + 8'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;
  assign done       = core_halted && (out_count == '0);

endmodule

// File: tb/tb_bf_io_bridge.sv
// Bench for bf_io_bridge: directed scenarios plus random traffic, compared against a queue-based model.
module tb_bf_io_bridge;
  import bf_pkg::*;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic [7:0]    core_in;
  logic          core_in_valid;
  logic          core_in_reading;
  logic [7:0]    core_out;
  logic          core_out_enable;
  logic          core_halted;
  logic [7:0]    host_rx_data;
  logic          host_rx_valid;
  logic          host_rx_ready;
  logic [7:0]    host_tx_data;
  logic          host_tx_valid;
  logic          host_tx_ready;
  logic [AW:0]   in_count;
  logic [AW:0]   out_count;
  logic          overflow;
  logic [7:0]    drop_count;
  logic          done;

  bf_io_bridge #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clock           (clock),
    .reset           (reset),
    .core_in         (core_in),
    .core_in_valid   (core_in_valid),
    .core_in_reading (core_in_reading),
    .core_out        (core_out),
    .core_out_enable (core_out_enable),
    .core_halted     (core_halted),
    .host_rx_data    (host_rx_data),
    .host_rx_valid   (host_rx_valid),
    .host_rx_ready   (host_rx_ready),
    .host_tx_data    (host_tx_data),
    .host_tx_valid   (host_tx_valid),
    .host_tx_ready   (host_tx_ready),
    .in_count        (in_count),
    .out_count       (out_count),
    .overflow        (overflow),
    .drop_count      (drop_count),
    .done            (done)
  );

  always #5 clock = ~clock;

  // Reference model: byte queues plus sticky flag and saturating drop tally.
  byte_t in_q[$];
  byte_t out_q[$];
  bit    ovf_m;
  int    drop_m;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".core_in_valid"}, {31'd0, core_in_valid}, (in_q.size() != 0) ? 1 : 0);
    check({tag, ".core_in"},       {24'd0, core_in},       (in_q.size() != 0) ? {24'd0, in_q[0]} : 0);
    check({tag, ".in_count"},      {27'd0, in_count},      in_q.size());
    check({tag, ".host_rx_ready"}, {31'd0, host_rx_ready}, (in_q.size() < DEPTH) ? 1 : 0);
    check({tag, ".host_tx_valid"}, {31'd0, host_tx_valid}, (out_q.size() != 0) ? 1 : 0);
    check({tag, ".host_tx_data"},  {24'd0, host_tx_data},  (out_q.size() != 0) ? {24'd0, out_q[0]} : 0);
    check({tag, ".out_count"},     {27'd0, out_count},     out_q.size());
    check({tag, ".overflow"},      {31'd0, overflow},      {31'd0, ovf_m});
    check({tag, ".drop_count"},    {24'd0, drop_count},    drop_m);
    check({tag, ".done"},          {31'd0, done},          (core_halted && out_q.size() == 0) ? 1 : 0);
  endtask

  // One clock: decide transfers from pre-edge model state and inputs, step the model, then compare.
  task automatic cycle(input string tag);
    bit    ip, ipp, op, opp, dr;
    byte_t rxd, cod;
    ip  = host_rx_valid && (in_q.size() < DEPTH);
    ipp = core_in_reading && (in_q.size() > 0);
    opp = host_tx_ready && (out_q.size() > 0);
    op  = core_out_enable && ((out_q.size() < DEPTH) || opp);
    dr  = core_out_enable && !op;
    rxd = host_rx_data;
    cod = core_out;
    @(posedge clock);
    if (ipp) void'(in_q.pop_front());
    if (ip)  in_q.push_back(rxd);
    if (opp) void'(out_q.pop_front());
    if (op)  out_q.push_back(cod);
    if (dr) begin
      ovf_m = 1'b1;
      if (drop_m < 255) drop_m++;
    end
    #1;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    core_in_reading = 1'b0;
    core_out        = 8'h00;
    core_out_enable = 1'b0;
    host_rx_data    = 8'h00;
    host_rx_valid   = 1'b0;
    host_tx_ready   = 1'b0;
  endtask

  initial begin
    idle_inputs();
    core_halted = 1'b1;
    reset       = 1'b1;
    ovf_m       = 1'b0;
    drop_m      = 0;
    repeat (2) @(posedge clock);
    #1;
    check_all("reset");
    check("reset.done_follows_halted", {31'd0, done}, 1);
    core_halted = 1'b0;
    #1;
    check("reset.done_low", {31'd0, done}, 0);
    reset = 1'b0;

    // Host-to-core basic
    host_rx_valid = 1'b1;
    host_rx_data  = 8'h41;
    check("h2c.valid_before_push", {31'd0, core_in_valid}, 0);
    cycle("h2c.push0");
    check("h2c.first_head", {24'd0, core_in}, 32'h41);
    host_rx_data = 8'h42;
    cycle("h2c.push1");
    host_rx_valid   = 1'b0;
    core_in_reading = 1'b1;
    cycle("h2c.read0");
    check("h2c.second_head", {24'd0, core_in}, 32'h42);
    cycle("h2c.read1");
    check("h2c.drained_valid", {31'd0, core_in_valid}, 0);
    check("h2c.drained_data", {24'd0, core_in}, 0);
    core_in_reading = 1'b0;

    // Input full, then a refused push alongside a core read
    host_rx_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      host_rx_data = 8'(8'h10 + i);
      cycle("infull.fill");
    end
    check("infull.ready_low", {31'd0, host_rx_ready}, 0);
    check("infull.count16", {27'd0, in_count}, 16);
    host_rx_data    = 8'hEE;
    core_in_reading = 1'b1;
    cycle("infull.refused");
    check("infull.count15", {27'd0, in_count}, 15);
    host_rx_valid = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      check("infull.order", {24'd0, core_in}, 32'h11 + i);
      cycle("infull.drain");
    end
    core_in_reading = 1'b0;

    // Output overflow
    host_tx_ready   = 1'b0;
    core_out_enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      core_out = 8'(i);
      cycle("ovf.strobe");
    end
    check("ovf.count16", {27'd0, out_count}, 16);
    check("ovf.flag", {31'd0, overflow}, 1);
    check("ovf.drops4", {24'd0, drop_count}, 4);
    core_out_enable = 1'b0;
    host_tx_ready   = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      check("ovf.drain_order", {24'd0, host_tx_data}, i);
      cycle("ovf.drain");
    end

    // Full output FIFO plus simultaneous host pop
    host_tx_ready   = 1'b0;
    core_out_enable = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      core_out = 8'(8'h80 + i);
      cycle("fullpop.fill");
    end
    core_out      = 8'hAA;
    host_tx_ready = 1'b1;
    cycle("fullpop.same_cycle");
    check("fullpop.count16", {27'd0, out_count}, 16);
    check("fullpop.drops_same", {24'd0, drop_count}, 4);
    core_out_enable = 1'b0;
    for (int i = 0; i < DEPTH; i++) cycle("fullpop.drain");
    host_tx_ready = 1'b0;

    // Empty read, then asynchronous reset with bytes buffered
    core_in_reading = 1'b1;
    cycle("empty_read");
    check("empty_read.count0", {27'd0, in_count}, 0);
    core_in_reading = 1'b0;
    host_rx_valid   = 1'b1;
    core_out_enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      host_rx_data = 8'(8'h30 + i);
      core_out     = 8'(8'h50 + i);
      cycle("rst.load");
    end
    idle_inputs();
    #2;
    reset = 1'b1;
    #1;
    in_q.delete();
    out_q.delete();
    ovf_m  = 1'b0;
    drop_m = 0;
    check_all("rst.async");
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    check_all("rst.released");

    // Done
    core_halted     = 1'b1;
    core_out_enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      core_out = 8'(8'h60 + i);
      cycle("done.load");
    end
    core_out_enable = 1'b0;
    check("done.pending", {31'd0, done}, 0);
    host_tx_ready = 1'b1;
    cycle("done.pop1");
    check("done.after_pop1", {31'd0, done}, 0);
    cycle("done.pop2");
    check("done.after_pop2", {31'd0, done}, 0);
    cycle("done.pop3");
    check("done.after_pop3", {31'd0, done}, 1);
    core_halted = 1'b0;
    #1;
    check("done.unhalted", {31'd0, done}, 0);

    // Random traffic on both paths
    for (int i = 0; i < 400; i++) begin
      host_rx_valid   = ($urandom_range(0, 3) != 0);
      host_rx_data    = 8'($urandom());
      core_in_reading = ($urandom_range(0, 2) == 0);
      core_out_enable = ($urandom_range(0, 1) == 0);
      core_out        = 8'($urandom());
      host_tx_ready   = ($urandom_range(0, 2) == 0);
      core_halted     = ($urandom_range(0, 3) == 0);
      cycle("rand");
    end

    // Drop counter saturation
    idle_inputs();
    core_out_enable = 1'b1;
    for (int i = 0; i < 280; i++) begin
      core_out = 8'(i);
      cycle("sat");
    end
    check("sat.drop_max", {24'd0, drop_count}, 32'hFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bf_io_bridge.md
# bf_io_bridge

Host-side I/O bridge for the BF core. It is the other end of the core's byte I/O ports. An input FIFO buffers host bytes and presents them to the core's `in` / `in_valid` / `in_reading` port. An output FIFO captures the core's `out` / `out_enable` strobes and streams them to the host over valid/ready. It sits between the core and the host UART or test harness, and it also reports run completion.

## Interface
- `DEPTH`, default 16: entries per FIFO. Must be a power of two and ≥2.
- `AW`, default `$clog2(DEPTH)`: pointer width. Counts are `AW+1` bits wide.

- `clock`  in  1  system clock
- `reset`  in  1  asynchronous, active-high
- `core_in`  out  8  head of input FIFO; 0 when empty
- `core_in_valid`  out  1  input FIFO non-empty
- `core_in_reading`  in  1  core consumes `core_in` at this edge
- `core_out`  in  8  byte emitted by the core
- `core_out_enable`  in  1  `core_out` valid this cycle; no backpressure
- `core_halted`  in  1  core in Halt state
- `host_rx_data`  in  8  byte from host
- `host_rx_valid`  in  1  host byte valid
- `host_rx_ready`  out  1  `!in_full`
- `host_tx_data`  out  8  head of output FIFO; 0 when empty
- `host_tx_valid`  out  1  output FIFO non-empty
- `host_tx_ready`  in  1  host accepts `host_tx_data`
- `in_count`  out  `AW+1`  input FIFO occupancy
- `out_count`  out  `AW+1`  output FIFO occupancy
- `overflow`  out  1  sticky: at least one core output byte was dropped
- `drop_count`  out  8  dropped core output bytes, saturating at 255
- `done`  out  1  `core_halted && out_count==0`

## Operation
- **Input path, push.** A push occurs when `host_rx_valid && host_rx_ready`.
  - `host_rx_ready` is combinational `in_count != DEPTH`.
  - A push is never accepted when the FIFO is full, even if a pop occurs in the same cycle.
- **Input path, pop.** A pop occurs when `core_in_reading && core_in_valid`.
  - If `core_in_reading` is asserted while the FIFO is empty, the request is ignored: no pointer or count change.
- **Input path, head.** `core_in` and `core_in_valid` are first-word-fall-through. Both are combinational from the FIFO head and count.
- **Output path, push.** A push occurs on `core_out_enable`.
  - Accepted if `out_count != DEPTH`, or if a host pop occurs in the same cycle.
  - Otherwise the byte is dropped, `overflow` is set to 1, and `drop_count` is incremented (saturating at 255).
- **Output path, pop.** A pop occurs when `host_tx_valid && host_tx_ready`.
- **Simultaneous push and pop.** Both take effect and the count is unchanged. Output order is preserved.
- **Flag clearing.** `overflow` and `drop_count` clear only on reset.
- **`done`.** Purely combinational. Drops to 0 if `core_halted` deasserts.
- **Arithmetic.** Pointers are `AW` bits and wrap modulo `DEPTH`. Counts never exceed `DEPTH`.

## Timing
- **Reset state.** Pointers, counts, `overflow` and `drop_count` are all 0. FIFO contents are don't-care.
  - Resulting outputs: `core_in_valid=0`, `core_in=0`, `host_tx_valid=0`, `host_tx_data=0`, `host_rx_ready=1`.
  - `done` equals `core_halted` while reset is asserted.
- **Reset mid-operation.** Asynchronous clear. All buffered bytes are discarded immediately.
- **Host-to-core latency.** A host byte accepted at edge N gives `core_in_valid=1` after edge N. The core can consume it at edge N+1. There is no same-cycle bypass.
- **Core-to-host latency.** A core byte strobed at edge N gives `host_tx_valid=1` after edge N. There is no bypass.
- **Throughput.** One byte per cycle per direction, sustained.
- **Count updates.** Counts update at the same edge as the corresponding push or pop.

## Structure
- **Package `bf_pkg`:**
  - `typedef logic [7:0] byte_t`
  - `localparam DROP_MAX = 8'hFF`
  - BF opcode constants (`OP_INC`, `OP_OUT`, `OP_IN`, `OP_NUL`, …), shared with the core and the benches.
- **Sub-module `bf_byte_fifo #(DEPTH)`.** Instantiated twice.
  - Ports: `push`, `push_data`, `pop`, `head`, `count`, `full`, `empty`, plus clock and reset.
  - `push` is accepted when `!full || pop`; pop is ignored when empty; `head` is 0 when empty.
- **Top-level logic.** Handshake qualification, overflow/drop counter, `done`.

## Test plan
- **Host-to-core basic.** Push 0x41 and 0x42 on consecutive cycles → `core_in_valid` rises the cycle after the first push; `core_in=0x41`. Assert `core_in_reading` for 2 cycles → 0x41 then 0x42 are delivered, then `core_in_valid=0` and `core_in=0`.
- **Input full.** Push `DEPTH`=16 bytes with no reads → `host_rx_ready=0` and `in_count=16`. A 17th push attempted in the same cycle as a core read is refused; `in_count=15` afterwards. Order is intact.
- **Output overflow.** Hold `host_tx_ready=0` and strobe `core_out_enable` 20 times with values 0..19 → `out_count=16`, `overflow=1`, `drop_count=4`. The host then drains bytes 0..15 in order.
- **Full plus simultaneous pop.** With the output FIFO full, strobe `core_out_enable`=0xAA and `host_tx_ready=1` in the same cycle → 0xAA is accepted, `out_count` stays 16, and `drop_count` is unchanged.
- **Empty read and reset.** Assert `core_in_reading` while empty → no count change. Assert reset asynchronously mid-stream with 5 bytes buffered → all counts are 0, `overflow=0`, `host_rx_ready=1` before the next edge.
- **Done.** Hold `core_halted=1` with 3 bytes in the output FIFO → `done=0` until the third host pop, then `done=1`. Deassert `core_halted` → `done=0`.
